// File: rtl/brick_fall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : brick_fall_ctrl
// Summary  : Falling-brick sequencer. It turns move pulses and gravity into
//            candidate placements, then commits, drops or locks the brick.
// Revision : 1.0  initial release
// ============================================================================
module brick_fall_ctrl #(
    parameter logic [24:0] GRAV_DIV = 25'd6_250_000,
    parameter int          X_W      = 4,
    parameter int          Y_W      = 5,
    parameter int          SPAWN_X  = 4,
    parameter int          SPAWN_Y  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mv_left,
    input  logic           mv_right,
    input  logic           rot,
    input  logic           soft_drop,
    input  logic           hard_drop,
    input  logic [2:0]     next_type,
    input  logic           cand_hit,
    input  logic           lock_done,
    output logic [2:0]     cur_type,
    output logic [1:0]     cur_dir,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic [2:0]     cand_type,
    output logic [1:0]     cand_dir,
    output logic [X_W-1:0] cand_x,
    output logic [Y_W-1:0] cand_y,
    output logic           cand_valid,
    output logic           lock,
    output logic           next_req,
    output logic           playing,
    output logic           game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_CHECK = 3'd3,
        S_LOCK  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_SPAWN = 3'd0,
        OP_HARD  = 3'd1,
        OP_ROT   = 3'd2,
        OP_LEFT  = 3'd3,
        OP_RIGHT = 3'd4,
        OP_DOWN  = 3'd5
    } op_t;

    // Pending-bit positions, highest priority in the top bit.
    localparam int P_HARD  = 4;
    localparam int P_ROT   = 3;
    localparam int P_LEFT  = 2;
    localparam int P_RIGHT = 1;
    localparam int P_DOWN  = 0;

    localparam logic [X_W-1:0] C_X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] C_Y_ONE = Y_W'(1);

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [4:0]     pend_q, pend_d;
    logic [24:0]    grav_cnt_q, grav_cnt_d;
    logic [2:0]     cur_type_q, cur_type_d, cand_type_q, cand_type_d;
    logic [1:0]     cur_dir_q, cur_dir_d, cand_dir_q, cand_dir_d;
    logic [X_W-1:0] cur_x_q, cur_x_d, cand_x_q, cand_x_d;
    logic [Y_W-1:0] cur_y_q, cur_y_d, cand_y_q, cand_y_d;
    logic           cand_valid_q, cand_valid_d;
    logic           lock_q, lock_d;
    logic           next_req_q, next_req_d;
    logic           playing_q, playing_d;
    logic           game_over_q, game_over_d;

    logic           w_active;
    logic           w_tick;
    logic [4:0]     w_pend;
    logic           w_go;
    logic [1:0]     w_nx_dir;
    logic [X_W-1:0] w_nx_x;
    logic [Y_W-1:0] w_nx_y;

    function automatic logic [4:0] op_mask(input op_t op);
        case (op)
            OP_HARD:  op_mask = 5'b1_0000;
            OP_ROT:   op_mask = 5'b0_1000;
            OP_LEFT:  op_mask = 5'b0_0100;
            OP_RIGHT: op_mask = 5'b0_0010;
            OP_DOWN:  op_mask = 5'b0_0001;
            default:  op_mask = 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pend_d      = pend_q;
        cur_type_d  = cur_type_q;
        cur_dir_d   = cur_dir_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cand_type_d = cand_type_q;
        cand_dir_d  = cand_dir_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        w_go        = 1'b0;
        w_nx_dir    = cur_dir_q;
        w_nx_x      = cur_x_q;
        w_nx_y      = cur_y_q;

        w_active = (state_q == S_FALL) || (state_q == S_CHECK);
        w_tick   = w_active && (grav_cnt_q == GRAV_DIV - 25'd1);
        // Commands and gravity only register while a brick is live.
        w_pend   = pend_q | ({hard_drop, rot, mv_left, mv_right, soft_drop | w_tick}
                             & {5{w_active}});

        if (!w_active)   grav_cnt_d = 25'd0;
        else if (w_tick) grav_cnt_d = 25'd0;
        else             grav_cnt_d = grav_cnt_q + 25'd1;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                cand_type_d = (next_type == 3'd0) ? 3'd1 : next_type;
                cand_dir_d  = 2'd0;
                cand_x_d    = X_W'(SPAWN_X);
                cand_y_d    = Y_W'(SPAWN_Y);
                pend_d      = 5'b0_0000;
                op_d        = OP_SPAWN;
                state_d     = S_CHECK;
            end
            S_FALL: begin
                pend_d = w_pend;
                if (w_pend[P_HARD]) begin
                    op_d   = OP_HARD;
                    w_go   = 1'b1;
                    w_nx_y = cur_y_q + C_Y_ONE;
                end else if (w_pend[P_ROT]) begin
                    op_d     = OP_ROT;
                    w_go     = 1'b1;
                    w_nx_dir = cur_dir_q + 2'd1;
                end else if (w_pend[P_LEFT]) begin
                    // Left edge is rejected here; the checker never sees it.
                    if (cur_x_q == '0) begin
                        pend_d[P_LEFT] = 1'b0;
                    end else begin
                        op_d   = OP_LEFT;
                        w_go   = 1'b1;
                        w_nx_x = cur_x_q - C_X_ONE;
                    end
                end else if (w_pend[P_RIGHT]) begin
                    op_d   = OP_RIGHT;
                    w_go   = 1'b1;
                    w_nx_x = cur_x_q + C_X_ONE;
                end else if (w_pend[P_DOWN]) begin
                    op_d   = OP_DOWN;
                    w_go   = 1'b1;
                    w_nx_y = cur_y_q + C_Y_ONE;
                end
                if (w_go) begin
                    cand_type_d = cur_type_q;
                    cand_dir_d  = w_nx_dir;
                    cand_x_d    = w_nx_x;
                    cand_y_d    = w_nx_y;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!cand_hit) begin
                    cur_type_d = cand_type_q;
                    cur_dir_d  = cand_dir_q;
                    cur_x_d    = cand_x_q;
                    cur_y_d    = cand_y_q;
                    // A hard drop keeps itself pending until it lands.
                    pend_d     = (op_q == OP_HARD) ? w_pend : (w_pend & ~op_mask(op_q));
                    state_d    = S_FALL;
                end else begin
                    pend_d = w_pend & ~op_mask(op_q);
                    case (op_q)
                        OP_SPAWN:         state_d = S_OVER;
                        OP_DOWN, OP_HARD: state_d = S_LOCK;
                        default:          state_d = S_FALL;
                    endcase
                end
            end
            S_LOCK: begin
                if (lock_done) state_d = S_SPAWN;
            end
            default: state_d = S_IDLE;
        endcase

        cand_valid_d = (state_d == S_CHECK);
        lock_d       = (state_d == S_LOCK) && (state_q != S_LOCK);
        next_req_d   = (state_d == S_SPAWN);
        playing_d    = (state_d == S_SPAWN) || (state_d == S_FALL) ||
                       (state_d == S_CHECK) || (state_d == S_LOCK);
        game_over_d  = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_SPAWN;
            pend_q       <= 5'b0_0000;
            grav_cnt_q   <= 25'd0;
            cur_type_q   <= 3'd0;
            cur_dir_q    <= 2'd0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cand_type_q  <= 3'd0;
            cand_dir_q   <= 2'd0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            cand_valid_q <= 1'b0;
            lock_q       <= 1'b0;
            next_req_q   <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pend_q       <= pend_d;
            grav_cnt_q   <= grav_cnt_d;
            cur_type_q   <= cur_type_d;
            cur_dir_q    <= cur_dir_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cand_type_q  <= cand_type_d;
            cand_dir_q   <= cand_dir_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            cand_valid_q <= cand_valid_d;
            lock_q       <= lock_d;
            next_req_q   <= next_req_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
        end
    end

    assign cur_type   = cur_type_q;
    assign cur_dir    = cur_dir_q;
    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign cand_type  = cand_type_q;
    assign cand_dir   = cand_dir_q;
    assign cand_x     = cand_x_q;
    assign cand_y     = cand_y_q;
    assign cand_valid = cand_valid_q;
    assign lock       = lock_q;
    assign next_req   = next_req_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_brick_fall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_brick_fall_ctrl
// Summary  : Directed bench for brick_fall_ctrl; a second instance with a
//            short gravity period exercises the gravity/lock path.
// Revision : 1.0  initial release
// ============================================================================
module tb_brick_fall_ctrl;

    logic       clk;
    logic       rst;
    logic       start, mv_left, mv_right, rot, soft_drop, hard_drop;
    logic [2:0] next_type;
    logic       cand_hit, lock_done;
    logic [2:0] cur_type, cand_type;
    logic [1:0] cur_dir, cand_dir;
    logic [3:0] cur_x, cand_x;
    logic [4:0] cur_y, cand_y;
    logic       cand_valid, lock, next_req, playing, game_over;

    logic       g_start, g_lock_done, g_cand_hit;
    logic [2:0] g_cur_type, g_cand_type;
    logic [1:0] g_cur_dir, g_cand_dir;
    logic [3:0] g_cur_x, g_cand_x;
    logic [4:0] g_cur_y, g_cand_y;
    logic       g_cand_valid, g_lock, g_next_req, g_playing, g_game_over;

    logic       hit_all, row_en;
    logic [4:0] hit_row;
    int         n_vec = 0;
    int         n_err = 0;

    // Board stand-in: hit everything, or any row at/below hit_row.
    assign cand_hit   = hit_all | (row_en & (cand_y >= hit_row));
    assign g_cand_hit = (g_cand_y >= 5'd6);

    brick_fall_ctrl #(.GRAV_DIV(25'd64)) dut (
        .clk(clk), .rst(rst), .start(start), .mv_left(mv_left), .mv_right(mv_right),
        .rot(rot), .soft_drop(soft_drop), .hard_drop(hard_drop), .next_type(next_type),
        .cand_hit(cand_hit), .lock_done(lock_done), .cur_type(cur_type), .cur_dir(cur_dir),
        .cur_x(cur_x), .cur_y(cur_y), .cand_type(cand_type), .cand_dir(cand_dir),
        .cand_x(cand_x), .cand_y(cand_y), .cand_valid(cand_valid), .lock(lock),
        .next_req(next_req), .playing(playing), .game_over(game_over)
    );

    brick_fall_ctrl #(.GRAV_DIV(25'd4)) dut_g (
        .clk(clk), .rst(rst), .start(g_start), .mv_left(1'b0), .mv_right(1'b0),
        .rot(1'b0), .soft_drop(1'b0), .hard_drop(1'b0), .next_type(next_type),
        .cand_hit(g_cand_hit), .lock_done(g_lock_done), .cur_type(g_cur_type),
        .cur_dir(g_cur_dir), .cur_x(g_cur_x), .cur_y(g_cur_y), .cand_type(g_cand_type),
        .cand_dir(g_cand_dir), .cand_x(g_cand_x), .cand_y(g_cand_y),
        .cand_valid(g_cand_valid), .lock(g_lock), .next_req(g_next_req),
        .playing(g_playing), .game_over(g_game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; mv_left = 0; mv_right = 0; rot = 0; soft_drop = 0;
        hard_drop = 0; lock_done = 0; next_type = 3'd3; hit_all = 0; row_en = 0;
        hit_row = 5'd31; g_start = 0; g_lock_done = 0;
        #2 rst = 1'b0;
        tick(); tick();
        chk("rst_cur_type",   32'(cur_type),   0);
        chk("rst_cur_x",      32'(cur_x),      0);
        chk("rst_cand_valid", 32'(cand_valid), 0);
        chk("rst_lock",       32'(lock),       0);
        chk("rst_next_req",   32'(next_req),   0);
        chk("rst_playing",    32'(playing),    0);
        chk("rst_game_over",  32'(game_over),  0);
        rst = 1'b1;
        tick();

        // Start and first spawn
        start = 1; tick(); start = 0;
        chk("spawn_next_req", 32'(next_req), 1);
        chk("spawn_playing",  32'(playing),  1);
        tick();
        chk("spawn_cand_valid", 32'(cand_valid), 1);
        chk("spawn_cand_type",  32'(cand_type),  3);
        chk("spawn_cand_x",     32'(cand_x),     4);
        chk("spawn_next_req_0", 32'(next_req),   0);
        tick();
        chk("spawn_cur_type", 32'(cur_type), 3);
        chk("spawn_cur_dir",  32'(cur_dir),  0);
        chk("spawn_cur_x",    32'(cur_x),    4);
        chk("spawn_cur_y",    32'(cur_y),    0);

        // Start while playing is ignored
        start = 1; tick(); start = 0;
        chk("start_ign_next_req", 32'(next_req),   0);
        chk("start_ign_valid",    32'(cand_valid), 0);

        // Four lefts reach the wall; the fifth never reaches CHECK
        for (int i = 1; i <= 4; i++) begin
            mv_left = 1; tick(); mv_left = 0;
            chk("left_cand_x", 32'(cand_x), 32'(4 - i));
            tick();
            chk("left_cur_x", 32'(cur_x), 32'(4 - i));
        end
        mv_left = 1; tick(); mv_left = 0;
        chk("left_wall_valid", 32'(cand_valid), 0);
        tick();
        chk("left_wall_valid2", 32'(cand_valid), 0);
        chk("left_wall_cur_x",  32'(cur_x),      0);

        // Rotation cycles 1,2,3,0
        for (int i = 1; i <= 4; i++) begin
            rot = 1; tick(); rot = 0;
            tick();
            chk("rot_cur_dir", 32'(cur_dir), 32'(i % 4));
        end

        // Blocked rotation is discarded
        hit_all = 1;
        rot = 1; tick(); rot = 0;
        chk("rot_hit_valid", 32'(cand_valid), 1);
        chk("rot_hit_cand_dir", 32'(cand_dir), 1);
        tick();
        hit_all = 0;
        chk("rot_hit_cur_dir", 32'(cur_dir),    0);
        chk("rot_hit_fall",    32'(cand_valid), 0);
        chk("rot_hit_lock",    32'(lock),       0);
        tick();
        chk("rot_hit_no_retry", 32'(cand_valid), 0);

        // Hard drop: one row per two cycles until the hit at row 8
        row_en = 1; hit_row = 5'd8;
        hard_drop = 1; tick(); hard_drop = 0;
        chk("hard_cand_y1", 32'(cand_y), 1);
        tick();
        chk("hard_cur_y1", 32'(cur_y), 1);
        for (int k = 2; k <= 7; k++) begin
            tick(); tick();
            chk("hard_cur_y", 32'(cur_y), 32'(k));
        end
        tick();
        chk("hard_last_valid",  32'(cand_valid), 1);
        chk("hard_last_cand_y", 32'(cand_y),     8);
        tick();
        chk("hard_lock",    32'(lock),    1);
        chk("hard_lock_y",  32'(cur_y),   7);
        chk("hard_playing", 32'(playing), 1);
        tick();
        chk("hard_lock_pulse", 32'(lock), 0);
        next_type = 3'd5;
        lock_done = 1; tick(); lock_done = 0;
        chk("relock_next_req", 32'(next_req), 1);
        tick(); tick();
        chk("respawn_type", 32'(cur_type), 5);
        chk("respawn_x",    32'(cur_x),    4);
        chk("respawn_y",    32'(cur_y),    0);

        // Left and rot together: rot wins, then left
        mv_left = 1; rot = 1; tick(); mv_left = 0; rot = 0;
        chk("pri_cand_dir", 32'(cand_dir), 1);
        chk("pri_cand_x",   32'(cand_x),   4);
        tick();
        chk("pri_cur_dir", 32'(cur_dir), 1);
        tick();
        chk("pri_left_cand_x", 32'(cand_x), 3);
        mv_right = 1; tick(); mv_right = 0;
        chk("pri_cur_x", 32'(cur_x), 3);
        tick();
        chk("chk_pulse_valid",  32'(cand_valid), 1);
        chk("chk_pulse_cand_x", 32'(cand_x),     4);
        tick();
        chk("chk_pulse_cur_x", 32'(cur_x), 4);

        // Soft drop into a hit locks; next spawn collides -> game over
        hit_all = 1;
        soft_drop = 1; tick(); soft_drop = 0;
        chk("soft_cand_y", 32'(cand_y), 1);
        tick();
        chk("soft_lock",   32'(lock),  1);
        chk("soft_cur_y",  32'(cur_y), 0);
        next_type = 3'd0;
        lock_done = 1; tick(); lock_done = 0;
        chk("over_next_req", 32'(next_req), 1);
        tick();
        chk("type0_as_1", 32'(cand_type), 1);
        tick();
        chk("over_game_over", 32'(game_over), 1);
        chk("over_playing",   32'(playing),   0);
        chk("over_cur_x",     32'(cur_x),     4);
        chk("over_cur_type",  32'(cur_type),  5);
        hit_all = 0;
        tick();
        chk("over_hold", 32'(game_over), 1);
        start = 1; tick(); start = 0;
        chk("restart_next_req", 32'(next_req),  1);
        chk("restart_over",     32'(game_over), 0);
        tick();
        chk("restart_valid", 32'(cand_valid), 1);

        // Asynchronous reset in CHECK
        rst = 1'b0; #1;
        chk("arst_valid",     32'(cand_valid), 0);
        chk("arst_cur_type",  32'(cur_type),   0);
        chk("arst_cand_type", 32'(cand_type),  0);
        chk("arst_playing",   32'(playing),    0);
        tick();
        chk("arst_lock", 32'(lock), 0);
        rst = 1'b1;
        tick();

        // Gravity on the GRAV_DIV=4 instance
        g_start = 1; tick(); g_start = 0;
        chk("g_next_req", 32'(g_next_req), 1);
        tick(); tick();
        chk("g_cur_y0", 32'(g_cur_y), 0);
        for (int k = 1; k <= 5; k++) begin
            repeat (4) tick();
            chk("g_cur_y", 32'(g_cur_y), 32'(k));
        end
        repeat (3) tick();
        chk("g_hit_valid",  32'(g_cand_valid), 1);
        chk("g_hit_cand_y", 32'(g_cand_y),     6);
        tick();
        chk("g_lock",       32'(g_lock),  1);
        chk("g_lock_cur_y", 32'(g_cur_y), 5);
        g_lock_done = 1; tick(); g_lock_done = 0;
        chk("g_respawn_req",  32'(g_next_req), 1);
        chk("g_respawn_lock", 32'(g_lock),     0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
